// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the K=3, rate-1/2 (7,5) hard-decision Viterbi decoder.
//   K, G0, G1, NUM_STATES : code definition
//   branch_out(state, u)  : encoder output {g0, g1} for a transition out of 'state' on input u
//   hamming2(a, b)        : Hamming distance of two 2-bit symbols (0..2)
package viterbi_pkg;

    localparam int unsigned K          = 3;
    localparam logic [2:0]  G0         = 3'b111;
    localparam logic [2:0]  G1         = 3'b101;
    localparam int unsigned NUM_STATES = 1 << (K - 1);

    // Encoder register is {u, b[n-1], b[n-2]}; state = {b[n-1], b[n-2]}.
    function automatic logic [1:0] branch_out(input logic [1:0] state, input logic u);
        logic [2:0] enc_reg;
        enc_reg = {u, state};
        return {^(enc_reg & G0), ^(enc_reg & G1)};
    endfunction

    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// One add-compare-select unit for next state NS of the K=3 trellis.
//   pm0_i/pm1_i : registered metrics of predecessors {NS[0],0} and {NS[0],1}
//   sr0_i/sr1_i : low TB_LEN-1 survivor bits of those predecessors
//   r_i         : received pair {r0, r1}
//   pm_o        : selected, saturated (not yet normalized) metric
//   sr_o        : updated survivor, newest decision at LSB
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned NS     = 0,
    parameter int unsigned PM_W   = 6,
    parameter int unsigned TB_LEN = 16
) (
    input  logic [PM_W-1:0]   pm0_i,
    input  logic [PM_W-1:0]   pm1_i,
    input  logic [TB_LEN-2:0] sr0_i,
    input  logic [TB_LEN-2:0] sr1_i,
    input  logic [1:0]        r_i,
    output logic [PM_W-1:0]   pm_o,
    output logic [TB_LEN-1:0] sr_o
);

    localparam logic [1:0]      NsBits = 2'(NS);
    localparam logic [1:0]      Pred0  = {NsBits[0], 1'b0};
    localparam logic [1:0]      Pred1  = {NsBits[0], 1'b1};
    localparam logic            U      = NsBits[1];
    localparam logic [PM_W-1:0] PmMax  = {PM_W{1'b1}};

    logic [1:0]      bm0;
    logic [1:0]      bm1;
    logic [PM_W:0]   sum0;
    logic [PM_W:0]   sum1;
    logic [PM_W-1:0] cand0;
    logic [PM_W-1:0] cand1;
    logic            sel;

    always_comb begin
        bm0   = hamming2(r_i, branch_out(Pred0, U));
        bm1   = hamming2(r_i, branch_out(Pred1, U));
        sum0  = {1'b0, pm0_i} + {{(PM_W-1){1'b0}}, bm0};
        sum1  = {1'b0, pm1_i} + {{(PM_W-1){1'b0}}, bm1};
        // Carry out means the sum passed the metric ceiling.
        cand0 = sum0[PM_W] ? PmMax : sum0[PM_W-1:0];
        cand1 = sum1[PM_W] ? PmMax : sum1[PM_W-1:0];
        // Strict compare: ties keep the lower-index predecessor.
        sel   = (cand1 < cand0);
        pm_o  = sel ? cand1 : cand0;
        sr_o  = {(sel ? sr1_i : sr0_i), U};
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, K=3 rate-1/2 (7,5), register-exchange survivors.
//   clk, rst : clock, asynchronous active-high reset
//   valid    : qualifies data_i; low holds all state
//   clr      : synchronous frame restart, overrides valid
//   data_i   : serial coded bits, g0 then g1 of each pair
//   data_o   : decoded bit, qualified by the one-cycle strobe valid_o
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_LEN  = 16,
    parameter int unsigned PM_W    = 6,
    parameter int unsigned PM_INIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic valid,
    input  logic clr,
    input  logic data_i,
    output logic data_o,
    output logic valid_o
);

    localparam int unsigned     CntW    = $clog2(TB_LEN + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(TB_LEN);
    localparam logic [PM_W-1:0] PmInit  = PM_W'(PM_INIT);

    logic              phase_q, phase_d;
    logic              r0_q, r0_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              step_q, step_d;
    logic              data_o_q, data_o_d;
    logic              valid_o_q, valid_o_d;
    logic [PM_W-1:0]   pm_q [NUM_STATES];
    logic [PM_W-1:0]   pm_d [NUM_STATES];
    logic [TB_LEN-1:0] sr_q [NUM_STATES];
    logic [TB_LEN-1:0] sr_d [NUM_STATES];

    logic [PM_W-1:0]   pm_acs  [NUM_STATES];
    logic [PM_W-1:0]   pm_norm [NUM_STATES];
    logic [TB_LEN-1:0] sr_acs  [NUM_STATES];
    logic [PM_W-1:0]   pm_min;
    logic [PM_W-1:0]   best_pm;
    logic [1:0]        best;

    for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
        viterbi_acs #(
            .NS     (ns),
            .PM_W   (PM_W),
            .TB_LEN (TB_LEN)
        ) u_acs (
            .pm0_i (pm_q[(ns % 2) * 2]),
            .pm1_i (pm_q[(ns % 2) * 2 + 1]),
            .sr0_i (sr_q[(ns % 2) * 2][TB_LEN-2:0]),
            .sr1_i (sr_q[(ns % 2) * 2 + 1][TB_LEN-2:0]),
            .r_i   ({r0_q, data_i}),
            .pm_o  (pm_acs[ns]),
            .sr_o  (sr_acs[ns])
        );
    end

    // Normalize so the smallest stored metric is always 0.
    always_comb begin
        pm_min = pm_acs[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_acs[i] < pm_min) pm_min = pm_acs[i];
        end
        for (int i = 0; i < NUM_STATES; i++) begin
            pm_norm[i] = pm_acs[i] - pm_min;
        end
    end

    // Best state from the registered metrics; lowest index wins ties.
    always_comb begin
        best    = 2'd0;
        best_pm = pm_q[0];
        for (int i = 1; i < NUM_STATES; i++) begin
            if (pm_q[i] < best_pm) begin
                best_pm = pm_q[i];
                best    = 2'(i);
            end
        end
    end

    always_comb begin
        phase_d   = phase_q;
        r0_d      = r0_q;
        cnt_d     = cnt_q;
        step_d    = 1'b0;
        data_o_d  = data_o_q;
        valid_o_d = 1'b0;
        pm_d      = pm_q;
        sr_d      = sr_q;

        // Output stage looks at state registered by the previous ACS step.
        if (step_q && (cnt_q == CntFull)) begin
            valid_o_d = 1'b1;
            data_o_d  = sr_q[best][TB_LEN-1];
        end

        if (valid) begin
            if (!phase_q) begin
                r0_d    = data_i;
                phase_d = 1'b1;
            end else begin
                phase_d = 1'b0;
                step_d  = 1'b1;
                pm_d    = pm_norm;
                sr_d    = sr_acs;
                if (cnt_q != CntFull) cnt_d = cnt_q + 1'b1;
            end
        end

        if (clr) begin
            phase_d   = 1'b0;
            r0_d      = 1'b0;
            cnt_d     = '0;
            step_d    = 1'b0;
            data_o_d  = 1'b0;
            valid_o_d = 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_d[i] = (i == 0) ? '0 : PmInit;
                sr_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= 1'b0;
            r0_q      <= 1'b0;
            cnt_q     <= '0;
            step_q    <= 1'b0;
            data_o_q  <= 1'b0;
            valid_o_q <= 1'b0;
            for (int i = 0; i < NUM_STATES; i++) begin
                pm_q[i] <= (i == 0) ? '0 : PmInit;
                sr_q[i] <= '0;
            end
        end else begin
            phase_q   <= phase_d;
            r0_q      <= r0_d;
            cnt_q     <= cnt_d;
            step_q    <= step_d;
            data_o_q  <= data_o_d;
            valid_o_q <= valid_o_d;
            pm_q      <= pm_d;
            sr_q      <= sr_d;
        end
    end

    assign data_o  = data_o_q;
    assign valid_o = valid_o_q;

endmodule

// File: tb/tb_viterbi_decoder.sv
// Self-checking bench for viterbi_decoder: directed streams plus a random noisy frame,
// compared cycle by cycle against a full-history Viterbi model.
module tb_viterbi_decoder;

    localparam int TB_LEN  = 16;
    localparam int PM_W    = 6;
    localparam int PM_INIT = 16;
    localparam int PM_MAX  = (1 << PM_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic valid;
    logic clr;
    logic data_i;
    logic data_o;
    logic valid_o;

    always #5 clk = ~clk;

    viterbi_decoder #(
        .TB_LEN  (TB_LEN),
        .PM_W    (PM_W),
        .PM_INIT (PM_INIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .valid   (valid),
        .clr     (clr),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: full decision history per state, plain integer metrics.
    int m_pm [4];
    bit m_phase;
    bit m_r0;
    int m_steps;
    bit m_pend;
    bit m_out;
    bit exp_valid;
    bit exp_data;
    bit hist [4][$];

    bit info_q  [$];
    bit coded_q [$];
    bit got_q   [$];
    int cyc;
    int step16_cyc;
    int first_pulse_cyc;

    function automatic int enc_g0(int s, int u);
        return u ^ ((s >> 1) & 1) ^ (s & 1);
    endfunction

    function automatic int enc_g1(int s, int u);
        return u ^ (s & 1);
    endfunction

    task automatic model_reset();
        m_pm[0] = 0;
        for (int i = 1; i < 4; i++) m_pm[i] = PM_INIT;
        m_phase   = 0;
        m_r0      = 0;
        m_steps   = 0;
        m_pend    = 0;
        m_out     = 0;
        exp_valid = 0;
        exp_data  = 0;
        for (int i = 0; i < 4; i++) hist[i].delete();
    endtask

    task automatic model_acs(input bit r0, input bit r1);
        int cand [4];
        int pick [4];
        bit nh [4][$];
        int mn;
        int best;
        for (int ns = 0; ns < 4; ns++) begin
            int u;
            int p0;
            int c0;
            int c1;
            u  = ns >> 1;
            p0 = (ns & 1) * 2;
            c0 = m_pm[p0] + (r0 != enc_g0(p0, u)) + (r1 != enc_g1(p0, u));
            c1 = m_pm[p0 + 1] + (r0 != enc_g0(p0 + 1, u)) + (r1 != enc_g1(p0 + 1, u));
            if (c0 > PM_MAX) c0 = PM_MAX;
            if (c1 > PM_MAX) c1 = PM_MAX;
            if (c1 < c0) begin
                cand[ns] = c1;
                pick[ns] = p0 + 1;
            end else begin
                cand[ns] = c0;
                pick[ns] = p0;
            end
        end
        for (int ns = 0; ns < 4; ns++) begin
            nh[ns] = hist[pick[ns]];
            nh[ns].push_back(bit'(ns >> 1));
        end
        mn = cand[0];
        for (int i = 1; i < 4; i++) if (cand[i] < mn) mn = cand[i];
        for (int i = 0; i < 4; i++) begin
            m_pm[i] = cand[i] - mn;
            hist[i] = nh[i];
        end
        m_steps++;
        if (m_steps >= TB_LEN) begin
            best = 0;
            for (int i = 1; i < 4; i++) if (m_pm[i] < m_pm[best]) best = i;
            m_pend = 1;
            m_out  = hist[best][m_steps - TB_LEN];
        end
    endtask

    task automatic model_edge(input bit v, input bit c, input bit d, output bit stepped);
        stepped = 0;
        if (rst || c) begin
            model_reset();
        end else begin
            exp_valid = m_pend;
            if (m_pend) exp_data = m_out;
            m_pend = 0;
            if (v) begin
                if (!m_phase) begin
                    m_r0    = d;
                    m_phase = 1;
                end else begin
                    m_phase = 0;
                    model_acs(m_r0, d);
                    stepped = 1;
                end
            end
        end
    endtask

    task automatic cycle(input bit v, input bit c, input bit d);
        bit stepped;
        valid  = v;
        clr    = c;
        data_i = d;
        @(posedge clk);
        model_edge(v, c, d, stepped);
        #1;
        cyc++;
        check_eq("valid_o", valid_o, exp_valid);
        check_eq("data_o", data_o, exp_data);
        if (stepped) begin
            if (m_steps == TB_LEN) step16_cyc = cyc;
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("pm[%0d]", i), int'(dut.pm_q[i]), m_pm[i]);
            end
        end
        if (valid_o) begin
            got_q.push_back(data_o);
            if (first_pulse_cyc < 0) first_pulse_cyc = cyc;
        end
    endtask

    task automatic do_reset();
        valid  = 0;
        clr    = 0;
        data_i = 0;
        rst    = 1;
        model_reset();
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        rst = 0;
        cycle(0, 0, 0);
    endtask

    task automatic encode_info();
        int s;
        coded_q.delete();
        s = 0;
        foreach (info_q[i]) begin
            coded_q.push_back(bit'(enc_g0(s, info_q[i])));
            coded_q.push_back(bit'(enc_g1(s, info_q[i])));
            s = (int'(info_q[i]) << 1) | (s >> 1);
        end
    endtask

    // Returns offset of the first valid_o pulse from the stream start.
    task automatic run_stream(input int pause_at, input int pause_len, input bit rnd_pause,
                              output int pulse_off);
        int start;
        got_q.delete();
        first_pulse_cyc = -1;
        step16_cyc      = -1;
        start           = cyc;
        foreach (coded_q[i]) begin
            cycle(1, 0, coded_q[i]);
            if (i == pause_at) repeat (pause_len) cycle(0, 0, 0);
            if (rnd_pause && (i % 2 == 0) && ($urandom_range(99) < 10))
                repeat ($urandom_range(3, 1)) cycle(0, 0, 0);
        end
        repeat (3) cycle(0, 0, 0);
        pulse_off = (first_pulse_cyc < 0) ? -1 : first_pulse_cyc - start;
    endtask

    task automatic check_decoded(input string tag, input int n);
        check_eq({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check_eq($sformatf("%s_bit%0d", tag, i), got_q[i], info_q[i]);
        end
    endtask

    initial begin
        int base_off;
        int off;
        int pm_min;
        bit pattern [6];

        cyc = 0;
        first_pulse_cyc = -1;
        step16_cyc = -1;
        pattern = '{1, 0, 1, 1, 0, 0};
        info_q.delete();
        foreach (pattern[i]) info_q.push_back(pattern[i]);
        repeat (TB_LEN - 1) info_q.push_back(0);

        // Reset state
        do_reset();
        check_eq("rst_phase", dut.phase_q, 0);
        check_eq("rst_pm0", int'(dut.pm_q[0]), 0);
        for (int i = 1; i < 4; i++) check_eq("rst_pmx", int'(dut.pm_q[i]), PM_INIT);

        // Error-free stream
        encode_info();
        check_eq("enc_pair1", {coded_q[0], coded_q[1]}, 3);
        check_eq("enc_pair4", {coded_q[6], coded_q[7]}, 1);
        run_stream(-1, 0, 0, base_off);
        check_decoded("clean", 6);
        check_eq("first_pulse_latency", first_pulse_cyc - step16_cyc, 1);

        // Single coded-bit error
        do_reset();
        encode_info();
        coded_q[2] = ~coded_q[2];
        run_stream(-1, 0, 0, off);
        check_decoded("one_err", 6);
        pm_min = PM_MAX;
        for (int i = 0; i < 4; i++) if (int'(dut.pm_q[i]) < pm_min) pm_min = int'(dut.pm_q[i]);
        check_eq("one_err_pm_min", pm_min, 0);

        // Pause inside pair 4 (after its r0, coded index 6)
        do_reset();
        encode_info();
        run_stream(6, 3, 0, off);
        check_decoded("pause", 6);
        check_eq("pause_shift", off, base_off + 3);

        // Asynchronous reset after 10 pairs, then resend
        do_reset();
        encode_info();
        for (int i = 0; i < 20; i++) cycle(1, 0, coded_q[i]);
        valid = 0;
        #2;
        rst = 1;
        model_reset();
        #1;
        check_eq("async_rst_valid_o", valid_o, 0);
        check_eq("async_rst_data_o", data_o, 0);
        check_eq("async_rst_phase", dut.phase_q, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        rst = 0;
        cycle(0, 0, 0);
        run_stream(-1, 0, 0, off);
        check_decoded("after_rst", 6);
        check_eq("after_rst_latency", off, base_off);

        // clr together with valid mid-pair: bit dropped, state restarts
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 0, coded_q[i]);
        cycle(1, 1, 1);
        check_eq("clr_phase", dut.phase_q, 0);
        check_eq("clr_pm0", int'(dut.pm_q[0]), 0);
        for (int i = 1; i < 4; i++) check_eq("clr_pmx", int'(dut.pm_q[i]), PM_INIT);
        run_stream(-1, 0, 0, off);
        check_decoded("after_clr", 6);
        check_eq("after_clr_latency", off, base_off);

        // Random frame at about 8% coded BER, random mid-pair pauses
        do_reset();
        info_q.delete();
        for (int i = 0; i < 1000; i++) info_q.push_back(bit'($urandom_range(1, 0)));
        repeat (TB_LEN - 1) info_q.push_back(0);
        encode_info();
        foreach (coded_q[i]) if ($urandom_range(99) < 8) coded_q[i] = ~coded_q[i];
        run_stream(-1, 0, 1, off);
        check_eq("random_count", got_q.size(), 1000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
